// File: rtl/reg_file_pkg.sv
// Shared constants for the register file: default widths and the index of
// the hardwired-zero register.
package reg_file_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int ZERO_REG   = 0;

    // True when the given index selects the hardwired-zero register.
    function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] idx);
        return (idx == ADDR_WIDTH'(ZERO_REG));
    endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port of the register file. Returns the stored word
// for the addressed register, forwards the in-flight write data when the
// write targets the same register, and forces the zero register to read 0.
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = reg_file_pkg::ADDR_WIDTH,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs,
    input  logic [ADDR_WIDTH-1:0]            raddr,
    input  logic [ADDR_WIDTH-1:0]            waddr,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic                             bypass_en,
    output logic [DATA_WIDTH-1:0]            rdata
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0] rdata_s;

    // Select zero, bypassed write data, or stored contents for this port.
    always_comb begin
        rdata_s = '0;
        if (raddr == ZERO_IDX) begin
            rdata_s = '0;
        end else if (bypass_en && (waddr == raddr)) begin
            rdata_s = wdata;
        end else begin
            rdata_s = regs[raddr];
        end
    end

    assign rdata = rdata_s;

endmodule

// File: rtl/reg_file.sv
// Two-read, one-write register file with write-to-read bypass, a hardwired
// zero register and a synchronous active-low clear of all contents.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = reg_file_pkg::ADDR_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] WRITEDATA,
    output logic [DATA_WIDTH-1:0] REGOUT1,
    output logic [DATA_WIDTH-1:0] REGOUT2,
    input  logic [ADDR_WIDTH-1:0] WRITEREG,
    input  logic [ADDR_WIDTH-1:0] READREG1,
    input  logic [ADDR_WIDTH-1:0] READREG2,
    input  logic                  WRITEENABLE,
    input  logic                  CLK,
    input  logic                  RESET
);

    localparam int                    DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] regs_r;
    logic                             bypass_en_s;

    // Forwarding is only meaningful while a real write can land at the edge;
    // during reset the write is dropped, so reads must show stored contents.
    assign bypass_en_s = WRITEENABLE & RESET;

    // Register storage: reset clears everything and wins over a write;
    // writes to the zero register are discarded so it always holds 0.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            regs_r <= '0;
        end else if (WRITEENABLE && (WRITEREG != ZERO_IDX)) begin
            regs_r[WRITEREG] <= WRITEDATA;
        end
    end

    reg_file_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_read_port1 (
        .regs      (regs_r),
        .raddr     (READREG1),
        .waddr     (WRITEREG),
        .wdata     (WRITEDATA),
        .bypass_en (bypass_en_s),
        .rdata     (REGOUT1)
    );

    reg_file_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_read_port2 (
        .regs      (regs_r),
        .raddr     (READREG2),
        .waddr     (WRITEREG),
        .wdata     (WRITEDATA),
        .bypass_en (bypass_en_s),
        .rdata     (REGOUT2)
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: a directed vector table covering reset,
// write, bypass, overwrite, zero register, enable and reset priority,
// followed by randomized traffic checked against an array-based model.
module tb_reg_file;

    logic [31:0] WRITEDATA;
    logic [31:0] REGOUT1;
    logic [31:0] REGOUT2;
    logic [4:0]  WRITEREG;
    logic [4:0]  READREG1;
    logic [4:0]  READREG2;
    logic        WRITEENABLE;
    logic        CLK;
    logic        RESET;

    int total;
    int bad;

    reg_file dut (
        .WRITEDATA   (WRITEDATA),
        .REGOUT1     (REGOUT1),
        .REGOUT2     (REGOUT2),
        .WRITEREG    (WRITEREG),
        .READREG1    (READREG1),
        .READREG2    (READREG2),
        .WRITEENABLE (WRITEENABLE),
        .CLK         (CLK),
        .RESET       (RESET)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs[15];

    // Reference contents: what each register should hold.
    logic [31:0] model_mem[32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    // Expected combinational read per the architectural rules.
    function automatic logic [31:0] model_read(input logic [4:0] idx, input logic rst,
                                               input logic we, input logic [4:0] wr,
                                               input logic [31:0] wd);
        if (idx == 5'd0) return 32'd0;
        if (rst && we && (wr == idx)) return wd;
        return model_mem[idx];
    endfunction

    task automatic drive(input logic rst, input logic we, input logic [4:0] wr,
                         input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
        RESET       = rst;
        WRITEENABLE = we;
        WRITEREG    = wr;
        WRITEDATA   = wd;
        READREG1    = r1;
        READREG2    = r2;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Rows are checked before their own edge; the edge then commits them.
        vecs[0]  = '{1'b1, 1'b1, 5'd2, 32'd95, 5'd2, 5'd0, 32'd95, 32'd0};  // bypass of first write
        vecs[1]  = '{1'b1, 1'b0, 5'd2, 32'd0,  5'd2, 5'd2, 32'd95, 32'd95}; // stored 95, both ports
        vecs[2]  = '{1'b1, 1'b1, 5'd1, 32'd28, 5'd1, 5'd2, 32'd28, 32'd95}; // bypass 28 before edge
        vecs[3]  = '{1'b1, 1'b0, 5'd1, 32'd0,  5'd1, 5'd1, 32'd28, 32'd28}; // 28 retained after edge
        vecs[4]  = '{1'b1, 1'b1, 5'd4, 32'd6,  5'd0, 5'd4, 32'd0,  32'd6};  // first overwrite value
        vecs[5]  = '{1'b1, 1'b0, 5'd4, 32'd15, 5'd0, 5'd4, 32'd0,  32'd6};  // 6 after first edge
        vecs[6]  = '{1'b1, 1'b1, 5'd4, 32'd15, 5'd4, 5'd4, 32'd15, 32'd15}; // second write bypassed
        vecs[7]  = '{1'b1, 1'b0, 5'd4, 32'd0,  5'd1, 5'd4, 32'd28, 32'd15}; // 15 after second edge
        vecs[8]  = '{1'b1, 1'b1, 5'd0, 32'd50, 5'd0, 5'd0, 32'd0,  32'd0};  // zero reg: no bypass
        vecs[9]  = '{1'b1, 1'b0, 5'd1, 32'd50, 5'd1, 5'd0, 32'd28, 32'd0};  // disabled write, zero stays 0
        vecs[10] = '{1'b1, 1'b0, 5'd1, 32'd0,  5'd1, 5'd0, 32'd28, 32'd0};  // index 1 still 28
        vecs[11] = '{1'b1, 1'b1, 5'd3, 32'd9,  5'd3, 5'd2, 32'd9,  32'd95}; // load 3 before reset test
        vecs[12] = '{1'b0, 1'b1, 5'd3, 32'd7,  5'd3, 5'd3, 32'd9,  32'd9};  // reset: no bypass, stored
        vecs[13] = '{1'b1, 1'b0, 5'd3, 32'd0,  5'd3, 5'd2, 32'd0,  32'd0};  // cleared, write dropped
        vecs[14] = '{1'b1, 1'b0, 5'd4, 32'd0,  5'd4, 5'd1, 32'd0,  32'd0};  // all cleared

        // Reset for one edge, then read indices 0 and 4.
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd4);
        @(posedge CLK);
        #1;
        check("reset_idx0", REGOUT1, 32'd0);
        check("reset_idx4", REGOUT2, 32'd0);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].wr, vecs[i].wd, vecs[i].r1, vecs[i].r2);
            #1;
            check($sformatf("vec%0d_port1", i), REGOUT1, vecs[i].e1);
            check($sformatf("vec%0d_port2", i), REGOUT2, vecs[i].e2);
            @(posedge CLK);
            #1;
        end

        // Directed rows end with every register cleared.
        for (int k = 0; k < 32; k++) model_mem[k] = 32'd0;

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            logic        rst;
            logic        we;
            logic [4:0]  wr;
            logic [31:0] wd;
            logic [4:0]  r1;
            logic [4:0]  r2;
            rst = ($urandom_range(0, 24) != 0);
            we  = ($urandom_range(0, 1) == 1);
            wr  = 5'($urandom_range(0, 31));
            wd  = $urandom;
            r1  = 5'($urandom_range(0, 31));
            r2  = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) r1 = wr;
            if ($urandom_range(0, 3) == 0) r2 = wr;
            drive(rst, we, wr, wd, r1, r2);
            #1;
            check($sformatf("rand%0d_port1", i), REGOUT1, model_read(r1, rst, we, wr, wd));
            check($sformatf("rand%0d_port2", i), REGOUT2, model_read(r2, rst, we, wr, wd));
            @(posedge CLK);
            if (!rst) begin
                for (int k = 0; k < 32; k++) model_mem[k] = 32'd0;
            end else if (we && (wr != 5'd0)) begin
                model_mem[wr] = wd;
            end
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
